// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory round-robin
// arbiter.
//   arb_state_t : sequencer states (IDLE, ACCESS, TURN)
//   ADDR_W_DEF  : default memory address width
//   DATA_W_DEF  : default memory data width
//   addr_t      : address word at the default width
//   data_t      : data word at the default width
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    // IDLE   : no access in progress
    // ACCESS : one-cycle memory read or write, gnt pulse active
    // TURN   : one dead bus cycle between a write and a read (either order)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick.
//   req   [N-1:0]     : candidate request vector
//   ptr   [PTR_W-1:0] : highest-priority index
//   win   [N-1:0]     : one-hot winner, the first set bit of req at or above
//                       ptr, wrapping from N-1 back to 0
//   valid             : at least one request present
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic             valid
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;

    // Requests at or above ptr get first pick. When there are none, the
    // search wraps to the lowest set bit of the full vector. x & -x isolates
    // the lowest set bit of x.
    always_comb begin
        hi_mask = ~((N'(1) << ptr) - N'(1));
        req_hi  = req & hi_mask;
        if (|req_hi) begin
            win = req_hi & (-req_hi);
        end else begin
            win = req & (-req);
        end
        valid = |req;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one single-port memory bus between NUM_REQ
// requesters. Each grant issues one single-cycle read or write; a read
// returns its data one cycle later with a one-hot rvalid pulse. A dead
// TURN cycle is inserted when back-to-back accesses change direction.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req/req_we          : per-requester request and direction (1 = write)
//   req_addr/req_wdata  : packed per-requester address and write data
//   gnt                 : one-hot pulse during the memory access cycle
//   rvalid/rdata        : one-hot read-data-valid pulse and read data
//   mem_addr/mem_wr_data: memory address and write data
//   mem_rd_data         : resolved memory bus data
//   mem_rd/mem_wr       : memory read / write strobes
//   grant_cnt/stats_clr : per-requester saturating grant counters and their
//                         clear (present only when MEM_ARB_STATS_EN is
//                         defined)
//
// Handshake: a requester raises req[i] with req_we/req_addr/req_wdata
// stable and holds them until it sees gnt[i]. The request is consumed in
// the cycle gnt[i] is high; the requester may then drop req[i] or present
// its next request. Dropping req[i] before gnt[i] withdraws the request.
// rvalid[i] has no ready; the requester must take rdata in that cycle.
//
// Optional feature macro: MEM_ARB_STATS_EN
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      mem_rd,
    output logic                      mem_wr
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
    input  logic                      stats_clr
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic               last_dir;     // 1 = last access was a write

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               go_access;
    logic               go_turn;

    // At the edge ending ACCESS the requester just served is still holding
    // req (it only sees gnt during this cycle), so it is masked out.
    // gnt is only non-zero during ACCESS, which makes it the mask directly.
    assign pick_req = (state == ACCESS) ? (req & ~gnt) : req;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .win   (win_oh),
        .valid (win_vld)
    );

    // Winner attributes and next pointer.
    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx   = PTR_W'(i);
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    // Only back-to-back accesses need a turnaround. From IDLE the bus has
    // already been quiet for a cycle, and from TURN it has just been turned,
    // so both go straight to ACCESS.
    always_comb begin
        go_access = 1'b0;
        go_turn   = 1'b0;
        if (win_vld) begin
            if ((state == ACCESS) && (win_we != last_dir)) begin
                go_turn = 1'b1;
            end else begin
                go_access = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            last_dir    <= 1'b0;
            gnt         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
        end else begin
            // Read data is on the bus during the read ACCESS cycle; capture
            // it at the edge that ends that cycle.
            rvalid <= '0;
            if ((state == ACCESS) && mem_rd) begin
                rdata  <= mem_rd_data;
                rvalid <= gnt;
            end

            gnt    <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (go_access) begin
                state       <= ACCESS;
                gnt         <= win_oh;
                mem_addr    <= win_addr;
                mem_wr_data <= win_wdata;
                mem_rd      <= ~win_we;
                mem_wr      <= win_we;
                ptr         <= ptr_nxt;
                last_dir    <= win_we;
            end else if (go_turn) begin
                state <= TURN;
            end else begin
                state <= IDLE;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating per-requester grant counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
